pc_unit: RTL and testbench

- Parametrised program-counter unit for the MIPS cores. Successor to the single-cycle PC block.
- Computes next-PC from sequential, conditional-branch (beq/bne), jump, jump-register, exception and exception-return sources.
- Adds a stall input, an EPC register and a return-address stack (RAS) that checks jr $ra targets.
- Sits at the head of fetch and feeds instruction-memory address and PC+4 to decode and the link path.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/ras_stack.sv | 64 ++++++
 rtl/pc_unit.sv | 120 ++++++++++++
 tb/tb_pc_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch/PC logic.
// Holds default widths and vectors, instruction-field widths, and the
// next-PC source encoding used to make waveforms readable.
package mips_pkg;

   localparam int          XLEN_DEF         = 32;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

   localparam int JADDR_W = 26;
   localparam int IMM_W   = 16;

   // Which source selected the next PC this cycle.
   typedef enum logic [2:0] {
      PC_SEQ,
      PC_BR,
      PC_J,
      PC_JR,
      PC_EXC,
      PC_ERET,
      PC_HOLD
   } pc_src_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack with circular storage.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   push, pop  : stack operations; both together replace the top entry
//                (or act as a plain push when the stack is empty)
//   din        : value to push
//   top        : most recently pushed valid entry
//   count      : number of valid entries (saturates at DEPTH)
module ras_stack #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [XLEN-1:0]                din,
   output logic [XLEN-1:0]                top,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   ptr;      // next free slot; when full it points at the oldest entry
   logic [PW-1:0]   top_idx;
   logic            not_empty;
   logic            full;

   // Explicit wrap so non-power-of-two depths stay circular.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
   endfunction

   assign top_idx   = ptr_dec(ptr);
   assign top       = mem[top_idx];
   assign not_empty = (count != '0);
   assign full      = (count == CW'(DEPTH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr   <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && pop && not_empty) begin
         // Pop then push: only the top entry changes.
         mem[top_idx] <= din;
      end else if (push) begin
         // When full this overwrites the oldest entry.
         mem[ptr] <= din;
         ptr      <= ptr_inc(ptr);
         if (!full) count <= count + 1'b1;
      end else if (pop && not_empty) begin
         ptr   <= ptr_dec(ptr);
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit at the head of fetch.
// Selects next PC from sequential, branch, jump, jump-register, exception
// and exception-return sources; keeps an EPC and a return-address stack
// that checks jr $ra targets.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   stall             : hold PC/EPC/RAS (exc still wins)
//   branch, branchNe, zFlag, bOffset : conditional branch controls
//   jump, jAddr       : j/jal
//   link              : instruction writes a return address (pushes RAS)
//   jumpReg, retHint, regTarget : jr/jalr, retHint marks a $ra return
//   exc, eret         : exception entry / return
//   pcOut, pcPlus4    : current PC and PC+4
//   epc               : saved exception PC
//   rasCount          : valid RAS entries
//   rasMispredict     : one-cycle pulse when a return check fails
module pc_unit
   import mips_pkg::*;
#(
   parameter int             XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
   parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEF),
   parameter int             RAS_DEPTH    = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              stall,
   input  logic                              branch,
   input  logic                              branchNe,
   input  logic                              zFlag,
   input  logic signed [XLEN-1:0]            bOffset,
   input  logic                              jump,
   input  logic [JADDR_W-1:0]                jAddr,
   input  logic                              link,
   input  logic                              jumpReg,
   input  logic                              retHint,
   input  logic [XLEN-1:0]                   regTarget,
   input  logic                              exc,
   input  logic                              eret,
   output logic [XLEN-1:0]                   pcOut,
   output logic [XLEN-1:0]                   pcPlus4,
   output logic [XLEN-1:0]                   epc,
   output logic [$clog2(RAS_DEPTH+1)-1:0]    rasCount,
   output logic                              rasMispredict
);

   // Low 28 bits of a jump target come from the instruction; the rest from PC+4.
   localparam logic [XLEN-1:0] REGION_MASK = ~XLEN'(28'hFFF_FFFF);

   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] j_target;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] ras_top;
   pc_src_t         pc_src;
   logic            ras_en;
   logic            ras_push;
   logic            ras_pop;
   logic            mispredict_next;

   assign pcPlus4   = pcOut + XLEN'(4);
   assign br_target = pcPlus4 + XLEN'(bOffset <<< 2);
   assign j_target  = (pcPlus4 & REGION_MASK) | XLEN'({jAddr, 2'b00});

   // The RAS only moves on a real, non-faulting instruction.
   assign ras_en   = !stall && !exc;
   assign ras_push = ras_en && link;
   assign ras_pop  = ras_en && jumpReg && retHint;

   // An empty-stack pop or a target disagreement is flagged; PC still follows regTarget.
   assign mispredict_next = ras_pop && ((rasCount == '0) || (ras_top != regTarget));

   always_comb begin
      pc_src = PC_SEQ;
      if (exc)                              pc_src = PC_EXC;
      else if (stall)                       pc_src = PC_HOLD;
      else if (eret)                        pc_src = PC_ERET;
      else if (jumpReg)                     pc_src = PC_JR;
      else if (jump)                        pc_src = PC_J;
      else if (branch && (zFlag ^ branchNe)) pc_src = PC_BR;
   end

   always_comb begin
      pc_next = pcPlus4;
      case (pc_src)
         PC_EXC:  pc_next = EXC_VECTOR;
         PC_HOLD: pc_next = pcOut;
         PC_ERET: pc_next = epc;
         PC_JR:   pc_next = regTarget;
         PC_J:    pc_next = j_target;
         PC_BR:   pc_next = br_target;
         default: pc_next = pcPlus4;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcOut         <= RESET_VECTOR;
         epc           <= '0;
         rasMispredict <= 1'b0;
      end else begin
         pcOut         <= pc_next;
         rasMispredict <= mispredict_next;
         if (exc) epc <= pcOut;
      end
   end

   ras_stack #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (pcPlus4),
      .top   (ras_top),
      .count (rasCount)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by randomized control
// traffic, all checked against a behavioural model held in this file.
module tb_pc_unit;

   localparam int          XLEN = 32;
   localparam int          D    = 4;
   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam logic [31:0] EV   = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall, branch, branchNe, zFlag, jump, link, jumpReg, retHint, exc, eret;
   logic [31:0] bOffset, regTarget;
   logic [25:0] jAddr;
   logic [31:0] pcOut, pcPlus4, epc;
   logic [2:0]  rasCount;
   logic        rasMispredict;

   always #5 clk = ~clk;

   pc_unit #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RV),
      .EXC_VECTOR   (EV),
      .RAS_DEPTH    (D)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch        (branch),
      .branchNe      (branchNe),
      .zFlag         (zFlag),
      .bOffset       (bOffset),
      .jump          (jump),
      .jAddr         (jAddr),
      .link          (link),
      .jumpReg       (jumpReg),
      .retHint       (retHint),
      .regTarget     (regTarget),
      .exc           (exc),
      .eret          (eret),
      .pcOut         (pcOut),
      .pcPlus4       (pcPlus4),
      .epc           (epc),
      .rasCount      (rasCount),
      .rasMispredict (rasMispredict)
   );

   int total = 0;
   int bad   = 0;

   // Reference state
   logic [31:0] m_pc, m_epc;
   logic        m_mis;
   logic [31:0] ras[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      stall = 0; branch = 0; branchNe = 0; zFlag = 0; jump = 0; link = 0;
      jumpReg = 0; retHint = 0; exc = 0; eret = 0;
      bOffset = '0; regTarget = '0; jAddr = '0;
   endtask

   task automatic model_reset();
      m_pc = RV; m_epc = '0; m_mis = 1'b0;
      ras.delete();
   endtask

   // Advance the reference by one clock using the current inputs.
   task automatic model_step();
      logic [31:0] p4;
      p4 = m_pc + 32'd4;
      if (exc) begin
         m_epc = m_pc;
         m_pc  = EV;
         m_mis = 1'b0;
      end else if (stall) begin
         m_mis = 1'b0;
      end else begin
         m_mis = 1'b0;
         if (jumpReg && retHint) begin
            if (ras.size() == 0) m_mis = 1'b1;
            else begin
               m_mis = (ras[$] != regTarget);
               void'(ras.pop_back());
            end
         end
         if (link) begin
            ras.push_back(p4);
            if (ras.size() > D) void'(ras.pop_front());
         end
         if (eret)                          m_pc = m_epc;
         else if (jumpReg)                  m_pc = regTarget;
         else if (jump)                     m_pc = {p4[31:28], jAddr, 2'b00};
         else if (branch && (zFlag ^ branchNe)) m_pc = p4 + (bOffset << 2);
         else                               m_pc = p4;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".pc"},    pcOut,    m_pc);
      check({tag, ".pc4"},   pcPlus4,  m_pc + 32'd4);
      check({tag, ".epc"},   epc,      m_epc);
      check({tag, ".cnt"},   {29'd0, rasCount}, ras.size());
      check({tag, ".mis"},   {31'd0, rasMispredict}, {31'd0, m_mis});
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic go(input logic [31:0] addr);
      idle();
      jumpReg = 1; regTarget = addr;
      step("go");
      idle();
   endtask

   logic [31:0] first_push;
   logic [31:0] held_pc;
   logic [2:0]  held_cnt;

   initial begin
      // 1: reset and sequential fetch
      idle();
      rst = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("rst");
      check("rst_pc", pcOut, 32'h0);
      rst = 1;
      step("seq"); check("seq4", pcOut, 32'd4);
      step("seq"); check("seq8", pcOut, 32'd8);

      // 2: branch conditions from pc=8
      branch = 1; bOffset = 32'd26; zFlag = 0; branchNe = 0;
      step("beq_nt"); check("beq_nt_pc", pcOut, 32'd12);
      go(32'd8);
      branch = 1; bOffset = 32'd26; zFlag = 1; branchNe = 0;
      step("beq_t"); check("beq_t_pc", pcOut, 32'd116);
      go(32'd8);
      branch = 1; bOffset = 32'd26; zFlag = 1; branchNe = 1;
      step("bne_nt"); check("bne_nt_pc", pcOut, 32'd12);
      go(32'd8);
      branch = 1; bOffset = 32'd26; zFlag = 0; branchNe = 1;
      step("bne_t"); check("bne_t_pc", pcOut, 32'd116);
      go(32'd8);
      branch = 1; bOffset = 32'hFFFF_FFFE; zFlag = 1; branchNe = 0;
      step("beq_back"); check("beq_back_pc", pcOut, 32'd4);

      // 3: jal then jr $ra
      go(32'h0040_0010);
      jump = 1; link = 1; jAddr = 26'd10;
      step("jal"); check("jal_pc", pcOut, 32'h0000_0028);
      check("jal_cnt", {29'd0, rasCount}, 32'd1);
      idle();
      jumpReg = 1; retHint = 1; regTarget = 32'h0040_0014;
      step("jr"); check("jr_pc", pcOut, 32'h0040_0014);
      check("jr_cnt", {29'd0, rasCount}, 32'd0);
      check("jr_mis", {31'd0, rasMispredict}, 32'd0);

      // 4: overflow and underflow
      idle();
      first_push = pcOut + 32'd4;
      repeat (5) begin link = 1; step("push"); end
      check("ovf_cnt", {29'd0, rasCount}, 32'd4);
      idle();
      repeat (4) begin
         jumpReg = 1; retHint = 1; regTarget = ras[$];
         step("pop"); check("pop_clean", {31'd0, rasMispredict}, 32'd0);
      end
      jumpReg = 1; retHint = 1; regTarget = first_push;
      step("pop5"); check("unf_mis", {31'd0, rasMispredict}, 32'd1);
      check("unf_cnt", {29'd0, rasCount}, 32'd0);
      idle(); link = 1; step("push1");
      idle(); jumpReg = 1; retHint = 1; regTarget = 32'hDEAD_BEEC;
      step("badpop"); check("bad_mis", {31'd0, rasMispredict}, 32'd1);
      idle(); step("after"); check("mis_clear", {31'd0, rasMispredict}, 32'd0);

      // 5: stall versus exception
      link = 1; step("push2"); idle();
      held_pc = pcOut; held_cnt = rasCount;
      stall = 1; jump = 1; link = 1; jAddr = 26'd5;
      repeat (3) step("stall");
      check("stall_pc", pcOut, held_pc);
      check("stall_cnt", {29'd0, rasCount}, {29'd0, held_cnt});
      go(32'h20);
      stall = 1; exc = 1; link = 1;
      step("exc"); check("exc_pc", pcOut, EV); check("exc_epc", epc, 32'h20);
      idle(); eret = 1;
      step("eret"); check("eret_pc", pcOut, 32'h20);

      // 6: asynchronous reset during a redirect
      idle(); jump = 1; jAddr = 26'd7;
      #2 rst = 0;
      #1;
      check("arst_pc", pcOut, RV);
      check("arst_epc", epc, 32'h0);
      check("arst_cnt", {29'd0, rasCount}, 32'd0);
      model_reset();
      @(posedge clk); #1;
      compare_all("arst_hold");
      rst = 1; idle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         exc      = ($urandom_range(0, 15) == 0);
         stall    = ($urandom_range(0, 7) == 0);
         eret     = ($urandom_range(0, 15) == 0);
         jumpReg  = ($urandom_range(0, 3) == 0);
         retHint  = $urandom_range(0, 1);
         jump     = ($urandom_range(0, 3) == 0);
         link     = ($urandom_range(0, 2) == 0);
         branch   = ($urandom_range(0, 2) == 0);
         branchNe = $urandom_range(0, 1);
         zFlag    = $urandom_range(0, 1);
         bOffset  = {{16{1'b0}}, 16'($urandom)};
         if (bOffset[15]) bOffset[31:16] = 16'hFFFF;
         jAddr    = 26'($urandom);
         if (ras.size() > 0 && $urandom_range(0, 2) != 0) regTarget = ras[$];
         else regTarget = $urandom;
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
